// File: rtl/fp_pkg.sv
// FP32 field constants and exponent classification shared by the operand
// pairer and the Floatadder stage.
package fp_pkg;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MAN_MSB  = 22;

  localparam logic [7:0] EXP_ZERO = 8'h00;
  localparam logic [7:0] EXP_MAX  = 8'hFF;

  // Zero/denormal or Inf/NaN exponent.
  function automatic logic is_special(input logic [31:0] word);
    logic [7:0] e;
    e = word[EXP_MSB:EXP_LSB];
    return (e == EXP_ZERO) || (e == EXP_MAX);
  endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO with explicit occupancy count and a combinational head word.
module fp_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign wr_en = push && !full && !flush;
  assign rd_en = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fp_operand_pairer.sv
// Buffers independent x/y FP32 operand streams and issues aligned pairs
// to the Floatadder, one per cycle, with a wrapping issued-pair counter.
module fp_operand_pairer
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [31:0]              in_x,
  input  logic                     in_x_valid,
  output logic                     in_x_ready,
  input  logic [31:0]              in_y,
  input  logic                     in_y_valid,
  output logic                     in_y_ready,
  input  logic                     out_en,
  output logic [31:0]              x,
  output logic [31:0]              y,
  output logic                     valid_inx,
  output logic                     valid_iny,
  output logic                     special,
  output logic [$clog2(DEPTH):0]   x_count,
  output logic [$clog2(DEPTH):0]   y_count,
  output logic [CNT_W-1:0]         pair_cnt
);

  logic [31:0]      x_head, y_head;
  logic             x_full, y_full, x_empty, y_empty;
  logic             x_push, y_push, issue;

  logic [31:0]      x_q, x_d, y_q, y_d;
  logic             valid_q, valid_d;
  logic             special_q, special_d;
  logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;

  // Ready is forced low during reset so no word is taken while state is held.
  assign in_x_ready = rst_n && !x_full && !flush;
  assign in_y_ready = rst_n && !y_full && !flush;
  assign x_push     = in_x_valid && in_x_ready;
  assign y_push     = in_y_valid && in_y_ready;
  assign issue      = out_en && !x_empty && !y_empty && !flush;

  fp_sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_x_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (x_push),
    .pop   (issue),
    .flush (flush),
    .din   (in_x),
    .dout  (x_head),
    .count (x_count),
    .full  (x_full),
    .empty (x_empty)
  );

  fp_sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_y_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (y_push),
    .pop   (issue),
    .flush (flush),
    .din   (in_y),
    .dout  (y_head),
    .count (y_count),
    .full  (y_full),
    .empty (y_empty)
  );

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    special_d  = special_q;
    valid_d    = 1'b0;
    pair_cnt_d = pair_cnt_q;
    if (issue) begin
      x_d        = x_head;
      y_d        = y_head;
      special_d  = is_special(x_head) || is_special(y_head);
      valid_d    = 1'b1;
      pair_cnt_d = pair_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      valid_q    <= 1'b0;
      special_q  <= 1'b0;
      pair_cnt_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      valid_q    <= valid_d;
      special_q  <= special_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign valid_inx = valid_q;
  assign valid_iny = valid_q;
  assign special   = special_q;
  assign pair_cnt  = pair_cnt_q;

endmodule

// File: doc/fp_operand_pairer.md
Name: fp_operand_pairer

Overview:
- Upstream feeder for the Floatadder stage.
- Accepts two independent IEEE-754 single-precision operand streams (x and y), each with a valid/ready handshake, and buffers each stream in its own FIFO.
- Issues one aligned operand pair per cycle, driving x, y, valid_inx and valid_iny. valid_inx and valid_iny are always asserted together, because the adder only computes when both are high in the same cycle.

Parameters:
- DEPTH, 4: entries per operand FIFO; power of two, minimum 2.
- CNT_W, 16: width of the issued-pair counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of both FIFOs
- in_x  in  32  x operand, FP32
- in_x_valid  in  1  in_x is valid
- in_x_ready  out  1  x FIFO can accept a word
- in_y  in  32  y operand, FP32
- in_y_valid  in  1  in_y is valid
- in_y_ready  out  1  y FIFO can accept a word
- out_en  in  1  downstream permits issue this cycle
- x  out  32  operand to adder
- y  out  32  operand to adder
- valid_inx  out  1  x valid to adder
- valid_iny  out  1  y valid to adder; always equal to valid_inx
- special  out  1  issued pair contains an operand with exponent 8'h00 or 8'hFF
- x_count  out  clog2(DEPTH)+1  current x FIFO occupancy
- y_count  out  clog2(DEPTH)+1  current y FIFO occupancy
- pair_cnt  out  CNT_W  total pairs issued, wraps

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers and counts go to 0.
  - x, y, valid_inx, valid_iny, special and pair_cnt go to 0.
  - in_x_ready and in_y_ready are held at 0 while rst_n is low.
- Push:
  - An x word is accepted on a clock edge when in_x_valid && in_x_ready; the y side works identically.
  - in_x_ready = (x_count != DEPTH) && !flush, computed combinationally from registered state.
  - There is no bypass of a simultaneous pop: a full FIFO drops ready even if a pop occurs in the same cycle.
- Issue decision (combinational):
  - issue = out_en && (x_count != 0) && (y_count != 0) && !flush.
- Issue registers:
  - On an edge where issue=1: pop both FIFO heads, load x/y with the head words, set valid_inx = valid_iny = 1, load special, and increment pair_cnt (wraps from 2^CNT_W-1 to 0).
  - On an edge where issue=0: valid_inx = valid_iny = 0; x, y and special hold their last values.
- Latency: a word accepted at edge k into an empty FIFO, with the other FIFO non-empty and out_en high, appears on x/y with valid high after edge k+1. Minimum latency is one cycle.
- Throughput: one pair per cycle when both FIFOs are non-empty and out_en is held high.
- Simultaneous push and pop on the same FIFO: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Count is stored explicitly, 0..DEPTH; full means count==DEPTH and empty means count==0.
- Imbalance: if one FIFO is empty, nothing issues and the other FIFO keeps filling until full. A single operand is never issued.
- Flush (synchronous, highest priority):
  - Clears pointers and counts.
  - Forces valid_inx/valid_iny to 0 on the next edge.
  - Blocks push and issue in the same cycle.
  - pair_cnt is not cleared.
- Reset asserted mid-operation: all buffered operands are discarded immediately and no partial pair is ever issued.
- special = (x[30:23]==8'h00 || x[30:23]==8'hFF || y[30:23]==8'h00 || y[30:23]==8'hFF), evaluated on the issued words. It is informational only; the pair is still issued.

Decomposition:
- Shared package fp_pkg:
  - FP32 field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_MSB=22.
  - EXP_ZERO=8'h00, EXP_MAX=8'hFF.
  - Function is_special(word) returning the exponent check.
  - The adder will also use this package.
- Sub-module fp_sync_fifo:
  - Parameters DEPTH and width 32.
  - Ports: push, pop, flush, din, dout (the head word, visible without registering), count, full, empty, plus the async active-low reset.
  - Instantiated twice, once for x and once for y. The top level holds only the issue logic, output registers and pair counter.

Test Plan:
- Basic pair: push x=32'h3F800000 (1.0), then y=32'h40000000 (2.0) with out_en=1 -> one cycle after y is accepted, x=3F800000, y=40000000, valid_inx=valid_iny=1 for exactly one cycle, special=0, pair_cnt=1.
- Imbalance/full: push 5 x words with no y and DEPTH=4 -> 4 x words accepted, in_x_ready=0, x_count=4, valid never asserted. Then push y=32'h3F800000 -> the first x word is issued paired with that y, and in_x_ready returns to 1.
- Streaming: both streams push 8 words back-to-back with out_en=1 -> 8 consecutive valid cycles in order, valid_inx==valid_iny on every cycle, pair_cnt=8.
- Backpressure: hold out_en=0 with both FIFOs full, then pulse it for 2 cycles -> exactly 2 pairs issued and counts go 4 to 2; simultaneous push and pop at count 2 leaves the count unchanged.
- Special/flush: issue x=32'h00000000 with y=32'h7F800000 -> special=1 with valid. Assert flush with 3 words buffered -> counts 0 and valid 0 on the next edge, pair_cnt retained.
- Reset mid-stream: drop rst_n asynchronously with words buffered -> all outputs 0 immediately and no pair issued after rst_n releases until new pushes arrive.
